// File: rtl/irq_timer_pkg.sv
// irq_timer_pkg: register map, TCON bit positions and default base address for irq_timer.
package irq_timer_pkg;
  localparam logic [1:0] OFF_TH = 2'd0;
  localparam logic [1:0] OFF_TL = 2'd1;
  localparam logic [1:0] OFF_TCON = 2'd2;
  localparam logic [1:0] OFF_PSC = 2'd3;
  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_IS = 2;
  localparam logic [31:0] DEFAULT_BASE = 32'h4000_0000;
endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: divides enabled cycles by (psc+1), emitting one tick per period.
module timer_prescaler #(
  parameter int PSC_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [PSC_W-1:0] psc,
  output logic             tick
);
  logic [PSC_W-1:0] cnt;
  assign tick = en & (cnt == psc);
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/irq_timer.sv
// irq_timer: memory-mapped interval timer raising a level irq on reload.
// Optional PSC register and prescaler under TIMER_PRESCALE_EN.
module irq_timer
  import irq_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE,
  parameter int PSC_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        MemRd,
  input  logic        MemWr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        irq
);
  logic [31:0] th, tl, tcon_rd, psc_rd;
  logic en, ie, is, tick, ovf;
  logic wr_th, wr_tl, wr_tcon;
  logic [1:0] off;
  logic unused_ok;
  assign unused_ok = &{1'b0, addr[1:0]};
  assign hit = addr[31:4] == BASE_ADDR[31:4];
  assign off = addr[3:2];
  assign wr_th = MemWr & hit & (off == OFF_TH);
  assign wr_tl = MemWr & hit & (off == OFF_TL);
  assign wr_tcon = MemWr & hit & (off == OFF_TCON);
`ifdef TIMER_PRESCALE_EN
  logic [PSC_W-1:0] psc;
  logic wr_psc;
  assign wr_psc = MemWr & hit & (off == OFF_PSC);
  assign psc_rd = 32'(psc);
  always_ff @(posedge clk or posedge reset)
    if (reset) psc <= '0;
    else if (wr_psc) psc <= wdata[PSC_W-1:0];
  timer_prescaler #(.PSC_W(PSC_W)) u_prescaler (
    .clk(clk), .reset(reset), .en(en), .clr(wr_psc), .psc(psc), .tick(tick)
  );
`else
  assign psc_rd = '0;
  assign tick = en;
`endif
  // a software TL write overrides the tick, so it also suppresses that cycle's overflow
  assign ovf = tick & (tl == 32'hFFFF_FFFF) & ~wr_tl;
  assign irq = ie & is;
  always_comb begin
    tcon_rd = '0;
    tcon_rd[TCON_EN] = en;
    tcon_rd[TCON_IE] = ie;
    tcon_rd[TCON_IS] = is;
  end
  assign rdata = !(MemRd && hit) ? '0 :
                 off == OFF_TH   ? th :
                 off == OFF_TL   ? tl :
                 off == OFF_TCON ? tcon_rd : psc_rd;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      th <= '0;
      tl <= '0;
      en <= 1'b0;
      ie <= 1'b0;
      is <= 1'b0;
    end else begin
      if (wr_th) th <= wdata;
      if (wr_tl) tl <= wdata;
      else if (tick) tl <= (tl == 32'hFFFF_FFFF) ? th : tl + 32'd1;
      if (wr_tcon) begin
        en <= wdata[TCON_EN];
        ie <= wdata[TCON_IE];
      end
      if (ovf && ie) is <= 1'b1;
      else if (wr_tcon && !wdata[TCON_IS]) is <= 1'b0;
    end
endmodule

// File: tb/tb_irq_timer.sv
// tb_irq_timer: directed vector table plus hand sequences for irq_timer.
module tb_irq_timer;
  import irq_timer_pkg::*;
  localparam logic [31:0] BASE = DEFAULT_BASE;
`ifdef TIMER_PRESCALE_EN
  localparam logic [31:0] PSC_EXP = 32'h0000_5678;
`else
  localparam logic [31:0] PSC_EXP = 32'h0;
`endif
  logic clk = 1'b0, reset = 1'b1, MemRd = 1'b0, MemWr = 1'b0;
  logic [31:0] addr = '0, wdata = '0, rdata;
  logic hit, irq;
  int checks = 0, errors = 0;
  logic [31:0] r;

  irq_timer dut (
    .clk(clk), .reset(reset), .addr(addr), .MemRd(MemRd), .MemWr(MemWr),
    .wdata(wdata), .rdata(rdata), .hit(hit), .irq(irq)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic wr;
    logic [1:0] off;
    logic [31:0] wd;
    logic [31:0] rd;
    logic irq;
  } vec_t;
  vec_t v[50];

  function automatic vec_t mk(logic w, logic [1:0] o, logic [31:0] d, logic [31:0] e, logic i);
    vec_t t;
    t.wr = w; t.off = o; t.wd = d; t.rd = e; t.irq = i;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] o, input logic [31:0] d);
    @(negedge clk);
    addr = BASE + {28'd0, o, 2'b00};
    wdata = d;
    MemWr = 1'b1;
    @(posedge clk);
    #1 MemWr = 1'b0;
  endtask

  task automatic rd(input logic [1:0] o, output logic [31:0] d);
    addr = BASE + {28'd0, o, 2'b00};
    MemRd = 1'b1;
    #1 d = rdata;
    MemRd = 1'b0;
  endtask

  initial begin
    v[0] = mk(0, OFF_TH, 0, 0, 0);
    v[1] = mk(0, OFF_TL, 0, 0, 0);
    v[2] = mk(0, OFF_TCON, 0, 0, 0);
    v[3] = mk(0, OFF_PSC, 0, 0, 0);
    v[4] = mk(1, OFF_TH, 32'hFFFF_FFF0, 0, 0);
    v[5] = mk(1, OFF_TL, 32'hFFFF_FFFD, 0, 0);
    v[6] = mk(0, OFF_TH, 0, 32'hFFFF_FFF0, 0);
    v[7] = mk(1, OFF_TCON, 3, 0, 0);
    v[8] = mk(0, OFF_TL, 0, 32'hFFFF_FFFD, 0);
    v[9] = mk(0, OFF_TL, 0, 32'hFFFF_FFFE, 0);
    v[10] = mk(0, OFF_TL, 0, 32'hFFFF_FFFF, 0);
    v[11] = mk(0, OFF_TL, 0, 32'hFFFF_FFF0, 1);
    v[12] = mk(0, OFF_TCON, 0, 7, 1);
    v[13] = mk(1, OFF_TCON, 3, 7, 1);
    v[14] = mk(0, OFF_TCON, 0, 3, 0);
    v[15] = mk(1, OFF_TCON, 7, 3, 0);
    v[16] = mk(0, OFF_TCON, 0, 3, 0);
    for (int i = 17; i <= 25; i++) v[i] = mk(0, OFF_TL, 0, 32'hFFFF_FFF0 + 32'(i - 11), 0);
    v[26] = mk(0, OFF_TL, 0, 32'hFFFF_FFFF, 0);
    v[27] = mk(0, OFF_TL, 0, 32'hFFFF_FFF0, 1);
    v[28] = mk(1, OFF_TCON, 3, 7, 1);
    v[29] = mk(0, OFF_TCON, 0, 3, 0);
    v[30] = mk(1, OFF_TL, 32'hFFFF_FFFE, 32'hFFFF_FFF3, 0);
    v[31] = mk(0, OFF_TL, 0, 32'hFFFF_FFFE, 0);
    v[32] = mk(1, OFF_TL, 5, 32'hFFFF_FFFF, 0);
    v[33] = mk(0, OFF_TL, 0, 5, 0);
    v[34] = mk(0, OFF_TCON, 0, 3, 0);
    v[35] = mk(1, OFF_TL, 32'hFFFF_FFFE, 7, 0);
    v[36] = mk(0, OFF_TL, 0, 32'hFFFF_FFFE, 0);
    v[37] = mk(1, OFF_TCON, 3, 3, 0);
    v[38] = mk(0, OFF_TCON, 0, 7, 1);
    v[39] = mk(1, OFF_TCON, 1, 7, 1);
    v[40] = mk(0, OFF_TCON, 0, 1, 0);
    v[41] = mk(1, OFF_TL, 32'hFFFF_FFFF, 32'hFFFF_FFF3, 0);
    v[42] = mk(0, OFF_TL, 0, 32'hFFFF_FFFF, 0);
    v[43] = mk(0, OFF_TL, 0, 32'hFFFF_FFF0, 0);
    v[44] = mk(0, OFF_TCON, 0, 1, 0);
    v[45] = mk(1, OFF_TCON, 0, 1, 0);
    v[46] = mk(0, OFF_TL, 0, 32'hFFFF_FFF3, 0);
    v[47] = mk(0, OFF_TL, 0, 32'hFFFF_FFF3, 0);
    v[48] = mk(1, OFF_PSC, 32'h1234_5678, 0, 0);
    v[49] = mk(0, OFF_PSC, 0, PSC_EXP, 0);

    #3 chk("irq_in_reset", {31'd0, irq}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // one vector per cycle: reads see the pre-write value, writes commit at the next edge
    foreach (v[i]) begin
      @(negedge clk);
      addr = BASE + {28'd0, v[i].off, 2'b00};
      wdata = v[i].wd;
      MemWr = v[i].wr;
      MemRd = 1'b1;
      #1;
      chk($sformatf("vec%0d_rdata", i), rdata, v[i].rd);
      chk($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, v[i].irq});
      chk($sformatf("vec%0d_hit", i), {31'd0, hit}, 1);
    end
    @(negedge clk);
    MemWr = 1'b0;
    MemRd = 1'b0;

    addr = BASE;
    #1 chk("rdata_no_rd", rdata, 0);
    addr = BASE + 32'd2;
    MemRd = 1'b1;
    #1 chk("unaligned_rd", rdata, 32'hFFFF_FFF0);
    chk("unaligned_hit", {31'd0, hit}, 1);
    addr = BASE + 32'h10;
    #1 chk("miss_hit", {31'd0, hit}, 0);
    chk("miss_rdata", rdata, 0);
    addr = BASE - 32'd4;
    #1 chk("below_hit", {31'd0, hit}, 0);
    MemRd = 1'b0;

    wr(OFF_TH, 0);
    wr(OFF_TL, 32'hFFFF_FFFF);
    wr(OFF_TCON, 3);
    repeat (2) @(negedge clk);
    chk("pre_reset_irq", {31'd0, irq}, 1);
    #2 reset = 1'b1;
    #1 chk("async_reset_irq", {31'd0, irq}, 0);
    rd(OFF_TL, r); chk("async_reset_tl", r, 0);
    rd(OFF_TCON, r); chk("async_reset_tcon", r, 0);
    @(negedge clk);
    reset = 1'b0;

`ifdef TIMER_PRESCALE_EN
    wr(OFF_PSC, 3);
    wr(OFF_TH, 0);
    wr(OFF_TL, 32'hFFFF_FFFE);
    wr(OFF_TCON, 3);
    for (int k = 0; k <= 9; k++) begin
      @(negedge clk);
      rd(OFF_TL, r);
      chk($sformatf("psc_tl_%0d", k), r, k < 4 ? 32'hFFFF_FFFE : k < 8 ? 32'hFFFF_FFFF : 32'h0);
      chk($sformatf("psc_irq_%0d", k), {31'd0, irq}, {31'd0, k >= 8});
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/irq_timer.md
# irq_timer

Memory-mapped interval timer that is the source side of the CPU's external interrupt line. It sits on the data-memory bus beside data RAM, counts a free-running 32-bit value, reloads it on overflow and raises a level `irq` to the pipeline's hazard/interrupt logic. `irq` stays asserted until software clears the status bit from the handler. Read data is combinational, so the MEM stage reads it the same cycle.

## Interface
- `BASE_ADDR`, 32'h4000_0000: byte address of TH; TL, TCON and PSC follow at +4, +8, +C.
- `PSC_W`, 16: prescaler width (used only with the macro).
- `clk`  in  1  system clock; rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `addr`  in  32  byte address from the MEM stage.
- `MemRd`  in  1  read strobe.
- `MemWr`  in  1  write strobe; the write commits at the `clk` edge.
- `wdata`  in  32  write data.
- `rdata`  out  32  read data; 0 when not selected or `MemRd`=0.
- `hit`  out  1  `addr` decodes to one of the timer words (word-aligned; `addr[1:0]` ignored).
- `irq`  out  1  interrupt request = TCON.IE & TCON.IS.

## Operation
- Registers:
  - TH (+0): reload value.
  - TL (+4): counter.
  - TCON (+8): bit0 EN, bit1 IE, bit2 IS; bits 31:3 read 0.
- Reset: TH=0, TL=0, TCON=0, PSC=0, prescale count=0. `irq`=0. `rdata`=0.
- A tick occurs every cycle while EN=1. With the macro, a tick occurs only when the prescale count reaches PSC.
- On a tick:
  - If TL==32'hFFFF_FFFF: TL←TH, and if IE=1 then IS←1.
  - Otherwise TL←TL+1 (32-bit modulo).
- Overflow with IE=0 reloads TL but never sets IS.
- TCON write: EN and IE take `wdata[1:0]`. IS←0 only if `wdata[2]`=0; writing 1 to IS has no effect, so software cannot self-trigger.
- TH and TL writes load the full 32 bits.
- Write to TL in the same cycle as a tick: the software value wins, and no overflow or IS set happens that cycle.
- Clearing IS in the same cycle an overflow sets it: the set wins and `irq` stays high.
- Clearing EN freezes TL and the prescale count. IS is kept.
- Writes to unmapped offsets inside the block's 16-byte window are ignored; reads of them return 0.
- Simultaneous `MemRd` and `MemWr` to the same word: `rdata` shows the pre-write value.

## Timing
- Read latency 0 (combinational from register state and `addr`).
- Write-to-effect latency 1: the value is visible on the cycle after the edge.
- `irq` rises 1 cycle after the overflow tick edge, i.e. the cycle after TL held FFFF_FFFF with a tick.
- Reload period with no prescaler = (2^32 − TH) cycles.
- `irq` drops 1 cycle after the clearing TCON write.
- `reset` asserted mid-count clears everything immediately (asynchronous) and drops `irq` without waiting for a clock edge.

## Configuration
- `TIMER_PRESCALE_EN` defined:
  - PSC register at +C (low `PSC_W` bits R/W, upper bits read 0).
  - A `PSC_W`-bit prescale count increments each EN cycle.
  - When the count equals PSC, it clears and a tick fires, giving one tick per (PSC+1) cycles. PSC=0 behaves as no prescaler.
  - A PSC write clears the prescale count.
- `TIMER_PRESCALE_EN` undefined:
  - Tick every EN cycle.
  - +C behaves as unmapped: reads 0, writes ignored.
  - No prescaler flops synthesized.

## Structure
- Shared package holds:
  - Word offsets OFF_TH=0, OFF_TL=1, OFF_TCON=2, OFF_PSC=3.
  - TCON bit indices TCON_EN=0, TCON_IE=1, TCON_IS=2.
  - The default peripheral base 32'h4000_0000.
- One sub-module, `timer_prescaler`: holds the count, takes PSC and EN, emits `tick`. It is instantiated only under `TIMER_PRESCALE_EN`; otherwise `tick`=EN.

## Test plan
- Reset then read TH/TL/TCON/+C → all 0, `irq`=0, `hit`=1 for each.
- TH=FFFF_FFF0, TL=FFFF_FFFD, TCON=3 → `irq` rises exactly 3 cycles after the TCON write edge, TL reads FFFF_FFF0 the cycle `irq` rises, and the next `irq` period is 16 cycles later.
- While `irq`=1, write TCON=3 → `irq` low next cycle. Write TCON=7 with IS=0 → IS stays 0.
- Write TL=5 in the same cycle TL=FFFF_FFFF ticks → TL=5 next cycle, IS unchanged. Clear IS in an overflow cycle with IE=1 → IS=1.
- TCON=1 (IE=0), run through an overflow → TL reloads to TH, `irq` stays 0. Assert `reset` mid-count between edges → all registers 0 immediately.
- With `TIMER_PRESCALE_EN`, PSC=3, TH=0, TL=FFFF_FFFE, TCON=3 → TL increments every 4 cycles, and `irq` rises 8 cycles after enable.
